seven_seg_scan_ctrl: RTL and testbench

Scan scheduler for the 8-column seven-segment display of the candy vending machine. It time-shares the single segment decoder across the 8 columns by presenting one digit code per column slot. It snapshots `sum` and `candy_sum` once per frame so a frame never mixes old and new values. It also runs a vend-acknowledge flash sequence. It sits between the vending FSM, which produces `sum`, `candy_sum` and `vend_pulse`, and the segment decoder / column drivers.

---
 rtl/seven_seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Scan scheduler for the 8-column seven-segment display: per-frame input snapshot plus vend-acknowledge flash.
// Optional macro SEG_SCAN_BLANK_EN inserts BLANK all-off cycles at the start of each column slot.
module seven_seg_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK        = 16,
  parameter int FLASH_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sum,
  input  logic [2:0] candy_sum,
  input  logic       vend_pulse,
  output logic [2:0] digit_sel,
  output logic [3:0] digit_val,
  output logic [7:0] display_column,
  output logic       blank
);
  localparam int CNT_MAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef SEG_SCAN_BLANK_EN
  typedef enum logic {S_BLANK, S_ON} state_t;
  state_t r_state;
`endif

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic [3:0]       r_val;
  logic [7:0]       r_col;
  logic             r_blank;
  logic [3:0]       r_sum;
  logic [2:0]       r_candy;
  logic [7:0]       r_flash;
  logic             r_supp;
  logic             r_init;

  logic             w_slot_end;
  logic             w_frame_start;
  logic [2:0]       w_next_sel;
  logic [7:0]       w_flash_pre;
  logic [7:0]       w_flash_post;
  logic             w_supp;

  function automatic logic [3:0] slot_code(input logic [2:0] sel, input logic [3:0] s,
                                           input logic [2:0] c);
    logic [3:0] v;
    v = 4'hF;
    case (sel)
      3'd0:    v = (s >= 4'd10) ? (s - 4'd10) : s;
      3'd1:    v = (s >= 4'd10) ? 4'd1 : 4'hF;
      3'd4:    v = {1'b0, c};
      default: v = 4'hF;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] col_mask(input logic [2:0] sel);
    return ~(8'h01 << sel);
  endfunction

`ifdef SEG_SCAN_BLANK_EN
  assign w_slot_end = (r_state == S_ON) && (r_cnt == CNT_W'(PRESCALE - 1));
`else
  assign w_slot_end = (r_cnt == CNT_W'(PRESCALE - 1));
`endif

  // The first edge out of reset behaves as a frame start so slot 0 gets a fresh snapshot.
  assign w_frame_start = r_init || (w_slot_end && (r_sel == 3'd7));
  assign w_next_sel    = r_init ? 3'd0 : (r_sel + 3'd1);

  // A vend on the frame-start edge counts for this frame; frames whose decremented count is odd are blanked.
  assign w_flash_pre  = vend_pulse ? 8'(FLASH_FRAMES) : r_flash;
  assign w_flash_post = (w_flash_pre != 8'd0) ? (w_flash_pre - 8'd1) : 8'd0;
  assign w_supp       = w_flash_post[0];

`ifndef SEG_SCAN_BLANK_EN
  logic w_supp_next;
  assign w_supp_next = w_frame_start ? w_supp : r_supp;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef SEG_SCAN_BLANK_EN
      r_state <= S_BLANK;
`endif
      r_cnt   <= '0;
      r_sel   <= 3'd0;
      r_val   <= 4'hF;
      r_col   <= 8'hFF;
      r_blank <= 1'b1;
      r_sum   <= 4'd0;
      r_candy <= 3'd0;
      r_flash <= 8'd0;
      r_supp  <= 1'b0;
      r_init  <= 1'b1;
    end else begin
      if (vend_pulse) r_flash <= 8'(FLASH_FRAMES);
      if (r_init || w_slot_end) begin
        r_init <= 1'b0;
        r_sel  <= w_next_sel;
        r_cnt  <= '0;
        if (w_frame_start) begin
          r_sum   <= sum;
          r_candy <= candy_sum;
          r_flash <= w_flash_post;
          r_supp  <= w_supp;
          r_val   <= slot_code(3'd0, sum, candy_sum);
        end else begin
          r_val <= slot_code(w_next_sel, r_sum, r_candy);
        end
`ifdef SEG_SCAN_BLANK_EN
        r_state <= S_BLANK;
        r_col   <= 8'hFF;
        r_blank <= 1'b1;
`else
        r_col   <= w_supp_next ? 8'hFF : col_mask(w_next_sel);
        r_blank <= w_supp_next;
`endif
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
`ifdef SEG_SCAN_BLANK_EN
        if ((r_state == S_BLANK) && (r_cnt == CNT_W'(BLANK - 1))) begin
          r_state <= S_ON;
          r_cnt   <= '0;
          r_col   <= r_supp ? 8'hFF : col_mask(r_sel);
          r_blank <= r_supp;
        end
`endif
      end
    end
  end

  assign digit_sel      = r_sel;
  assign digit_val      = r_val;
  assign display_column = r_col;
  assign blank          = r_blank;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a frame/slot arithmetic model pushes per-cycle expectations.
module tb_seven_seg_scan_ctrl;
  localparam int P = 4;
  localparam int B = 2;
  localparam int F = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int B_EFF = B;
`else
  localparam int B_EFF = 0;
`endif
  localparam int L     = B_EFF + P;
  localparam int FRAME = 8 * L;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sum = 4'd0;
  logic [2:0] candy_sum = 3'd0;
  logic       vend_pulse = 1'b0;
  logic [2:0] digit_sel;
  logic [3:0] digit_val;
  logic [7:0] display_column;
  logic       blank;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] val;
    logic [7:0] col;
    logic       blk;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   m_k = 0;
  int   m_cnt = 0;
  int   m_s = 0;
  int   m_c = 0;
  logic m_supp = 1'b0;

  seven_seg_scan_ctrl #(.PRESCALE(P), .BLANK(B), .FLASH_FRAMES(F)) u_dut (
    .clk(clk), .reset(reset), .sum(sum), .candy_sum(candy_sum), .vend_pulse(vend_pulse),
    .digit_sel(digit_sel), .digit_val(digit_val), .display_column(display_column), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_code(input int slot, input int s, input int c);
    case (slot)
      0:       return 4'(s % 10);
      1:       return (s >= 10) ? 4'd1 : 4'hF;
      4:       return 4'(c);
      default: return 4'hF;
    endcase
  endfunction

  // One clock: model the edge from the inputs it samples, queue the expected outputs.
  task automatic cycle();
    exp_t       e;
    int         idx, slot, ph, pre;
    logic       lit;
    logic [7:0] one;
    @(posedge clk);
    if (!reset) begin
      m_k   = 0;
      m_cnt = 0;
      e.sel = 3'd0; e.val = 4'hF; e.col = 8'hFF; e.blk = 1'b1;
      q.push_back(e);
    end else begin
      idx  = m_k % FRAME;
      slot = idx / L;
      ph   = idx % L;
      if (idx == 0) begin
        m_s    = int'(sum);
        m_c    = int'(candy_sum);
        pre    = vend_pulse ? F : m_cnt;
        m_cnt  = (pre != 0) ? pre - 1 : 0;
        m_supp = (m_cnt % 2) == 1;
      end else if (vend_pulse) begin
        m_cnt = F;
      end
      lit   = !m_supp && (ph >= B_EFF);
      one   = 8'h01;
      e.sel = 3'(slot);
      e.val = exp_code(slot, m_s, m_c);
      e.col = lit ? ~(one << slot) : 8'hFF;
      e.blk = !lit;
      q.push_back(e);
      m_k++;
    end
    #1;
  endtask

  task automatic wait_idx(input int target);
    int n;
    n = 0;
    while (((m_k % FRAME) != target) && (n < 2 * FRAME)) begin
      cycle();
      n++;
    end
    chk("wait_idx", m_k % FRAME, target);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("digit_sel", digit_sel, e.sel);
      chk("digit_val", digit_val, e.val);
      chk("display_column", display_column, e.col);
      chk("blank", blank, e.blk);
      chk("one_col_low", ($countones(~display_column) <= 1), 1);
    end
  end

  initial begin
    sum = 4'd7; candy_sum = 3'd3;
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2 * FRAME) cycle();

    sum = 4'd13;
    repeat (FRAME) cycle();

    sum = 4'd5;
    repeat (FRAME) cycle();
    wait_idx(3 * L + 1);
    sum = 4'd9;
    repeat (2 * FRAME) cycle();

    // vend in frame N, then a second vend inside the first blanked frame
    wait_idx(2 * L);
    vend_pulse = 1'b1; cycle(); vend_pulse = 1'b0;
    repeat (FRAME) cycle();
    vend_pulse = 1'b1; cycle(); vend_pulse = 1'b0;
    repeat (4 * FRAME) cycle();

    // vend coinciding with the frame-start edge
    wait_idx(0);
    vend_pulse = 1'b1; cycle(); vend_pulse = 1'b0;
    repeat (3 * FRAME) cycle();

    sum = 4'd15; candy_sum = 3'd7;
    repeat (2 * FRAME) cycle();

    // asynchronous reset in the middle of slot 5
    wait_idx(5 * L + B_EFF + 1);
    reset = 1'b0;
    q.delete();
    #1;
    chk("rst_digit_sel", digit_sel, 3'd0);
    chk("rst_digit_val", digit_val, 4'hF);
    chk("rst_display_column", display_column, 8'hFF);
    chk("rst_blank", blank, 1'b1);
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2 * FRAME) cycle();

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
